// File: rtl/instr_fetch.sv
// Instruction-fetch stage of the RISC CPU, directly upstream of the Controller.
//
// Holds the program counter and fetches one instruction per step over a req/ack
// handshake. The fetched word goes into an instruction register whose opcode is
// presented to the Controller. The stage then waits for pc_write and resolves
// branch/branch_not against the ALU zero flag to select the next pc.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   imem_req        - fetch request (combinational, high only while fetching)
//   imem_addr       - fetch address, always equal to pc (combinational)
//   imem_rdata      - fetched word, valid when imem_ack=1
//   imem_ack        - memory response, may arrive in the request cycle
//   pc_write        - Controller commit of the current instruction
//   branch          - branch taken when zero=1
//   branch_not      - branch taken when zero=0 (both high: unconditional jump)
//   zero            - ALU zero flag for the current instruction
//   branch_target   - branch destination from the datapath
//   pc              - address of the instruction held in instr
//   instr, opcode   - instruction register and its top 4 bits
//   instr_valid     - instr/opcode valid for the Controller
//   halted          - halt opcode fetched, fetching stopped until reset
module instr_fetch #(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  input  logic                   pc_write,
  input  logic                   branch,
  input  logic                   branch_not,
  input  logic                   zero,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode,
  output logic                   instr_valid,
  output logic                   halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e              state_q;
  logic                taken;
  logic [PC_WIDTH-1:0] next_pc;
  logic [3:0]          fetched_op;

  always_comb begin
    taken      = (branch & zero) | (branch_not & ~zero);
    // pc + 1 wraps naturally at the PC_WIDTH boundary
    next_pc    = taken ? branch_target : pc + PC_WIDTH'(1);
    fetched_op = imem_rdata[INSTR_WIDTH-1 -: 4];
  end

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc          <= RESET_PC;
      instr       <= '0;
      opcode      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end
        StFetch: begin
          if (imem_ack) begin
            instr  <= imem_rdata;
            opcode <= fetched_op;
            if (fetched_op == HALT_OPCODE) begin
              state_q <= StHalt;
              halted  <= 1'b1;
            end else begin
              state_q     <= StIssue;
              instr_valid <= 1'b1;
            end
          end
        end
        StIssue: begin
          // pc only moves on the exit edge so the opcode is stable through issue
          if (pc_write) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state_q     <= StFetch;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        pc_write;
  logic        branch;
  logic        branch_not;
  logic        zero;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        halted;

  instr_fetch #(
    .PC_WIDTH   (8),
    .INSTR_WIDTH(16),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .pc_write     (pc_write),
    .branch       (branch),
    .branch_not   (branch_not),
    .zero         (zero),
    .branch_target(branch_target),
    .pc           (pc),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .halted       (halted)
  );

  typedef struct {
    logic [7:0] addr;
    int         dly;
  } fetch_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } issue_t;

  typedef struct {
    logic       br;
    logic       bn;
    logic       z;
    logic [7:0] tgt;
    int         hold;
  } ctrl_t;

  fetch_t fq[$];
  int     dq[$];
  issue_t iq[$];
  ctrl_t  cq[$];

  logic [15:0] mem [256];

  int checks;
  int failures;
  bit mon_en;
  bit man;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks after the queued number of wait cycles
  initial begin
    bit busy;
    int cnt;
    int d;
    busy = 0;
    cnt  = 0;
    d    = 0;
    forever begin
      @(negedge clk);
      if (!man) begin
        if (imem_req) begin
          if (!busy) begin
            busy = 1;
            cnt  = 0;
            d    = (dq.size() > 0) ? dq.pop_front() : 0;
          end
          if (cnt == d) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
          end else begin
            imem_ack = 1'b0;
            cnt++;
          end
        end else begin
          busy     = 0;
          imem_ack = 1'b0;
        end
      end
    end
  end

  // Controller model: junk on control inputs outside issue, queued controls inside
  initial begin
    bit    in_issue;
    int    hcnt;
    ctrl_t c;
    in_issue = 0;
    hcnt     = 0;
    c        = '{br: 1'b0, bn: 1'b0, z: 1'b0, tgt: 8'h00, hold: 0};
    forever begin
      @(negedge clk);
      if (instr_valid) begin
        if (!in_issue) begin
          if (cq.size() > 0) begin
            c        = cq.pop_front();
            in_issue = 1;
            hcnt     = 0;
          end
        end
        if (in_issue && hcnt == c.hold) begin
          pc_write      = 1'b1;
          branch        = c.br;
          branch_not    = c.bn;
          zero          = c.z;
          branch_target = c.tgt;
          in_issue      = 0;
        end else begin
          pc_write      = 1'b0;
          branch        = 1'b1;
          branch_not    = 1'b1;
          zero          = 1'b1;
          branch_target = 8'hAA;
          hcnt++;
        end
      end else begin
        in_issue      = 0;
        pc_write      = 1'b1;
        branch        = 1'b1;
        branch_not    = 1'b0;
        zero          = 1'b1;
        branch_target = 8'hAA;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_req;
    logic        prev_valid;
    logic        prev_ack;
    logic [3:0]  ack_op;
    logic [7:0]  cur_addr;
    int          req_cnt;
    int          exp_req;
    logic [7:0]  hold_pc;
    logic [3:0]  hold_op;
    fetch_t      f;
    issue_t      e;
    prev_req   = 0;
    prev_valid = 0;
    prev_ack   = 0;
    ack_op     = '0;
    cur_addr   = '0;
    req_cnt    = 0;
    exp_req    = 0;
    hold_pc    = '0;
    hold_op    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (imem_req && !prev_req) begin
          if (fq.size() == 0) begin
            check("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
          end else begin
            f = fq.pop_front();
            check("fetch_addr", 32'(imem_addr), 32'(f.addr));
            check("fetch_pc", 32'(pc), 32'(f.addr));
            cur_addr = f.addr;
            exp_req  = f.dly + 1;
          end
          req_cnt = 1;
        end else if (imem_req) begin
          check("fetch_addr_stable", 32'(imem_addr), 32'(cur_addr));
          req_cnt++;
        end else if (prev_req) begin
          check("req_cycles", 32'(req_cnt), 32'(exp_req));
        end

        if (prev_ack) begin
          check("valid_after_ack", 32'(instr_valid), 32'(ack_op != 4'hF));
          check("halt_after_ack", 32'(halted), 32'(ack_op == 4'hF));
        end

        if (instr_valid && !prev_valid) begin
          if (iq.size() == 0) begin
            check("issue_unexpected", 32'(instr), 32'hFFFF_FFFF);
          end else begin
            e = iq.pop_front();
            check("issue_pc", 32'(pc), 32'(e.pc));
            check("issue_instr", 32'(instr), 32'(e.instr));
            check("issue_opcode", 32'(opcode), 32'(e.instr[15:12]));
          end
          hold_pc = pc;
          hold_op = opcode;
        end else if (instr_valid) begin
          check("hold_pc", 32'(pc), 32'(hold_pc));
          check("hold_opcode", 32'(opcode), 32'(hold_op));
          check("hold_no_req", 32'(imem_req), 32'(0));
        end

        prev_req   = imem_req;
        prev_valid = instr_valid;
        prev_ack   = imem_req && imem_ack;
        ack_op     = imem_rdata[15:12];
      end
    end
  end

  task automatic push_step(input logic [7:0] addr, input int dly, input logic br,
                           input logic bn, input logic z, input logic [7:0] tgt,
                           input int hold);
    fq.push_back('{addr: addr, dly: dly});
    dq.push_back(dly);
    iq.push_back('{pc: addr, instr: mem[addr]});
    cq.push_back('{br: br, bn: bn, z: z, tgt: tgt, hold: hold});
  endtask

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    mon_en        = 0;
    man           = 0;
    rst           = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 16'h0000;
    pc_write      = 1'b0;
    branch        = 1'b0;
    branch_not    = 1'b0;
    zero          = 1'b0;
    branch_target = 8'h00;

    for (int a = 0; a < 256; a++) mem[a] = 16'h2000 | 16'(a);
    mem[8'h00] = 16'h1234;
    mem[8'h40] = 16'hF000;

    //        addr   dly br  bn  z   tgt    hold   next
    push_step(8'h00, 0, 0, 0, 0, 8'h00, 0);  // 01
    push_step(8'h01, 3, 0, 0, 1, 8'h33, 0);  // 02
    push_step(8'h02, 0, 0, 0, 0, 8'h00, 1);  // 03
    push_step(8'h03, 1, 0, 0, 0, 8'h00, 0);  // 04
    push_step(8'h04, 0, 0, 0, 0, 8'h00, 0);  // 05
    push_step(8'h05, 0, 1, 0, 1, 8'h20, 0);  // 20 branch taken
    push_step(8'h20, 0, 1, 1, 0, 8'h05, 0);  // 05 jump
    push_step(8'h05, 0, 1, 0, 0, 8'h20, 0);  // 06 branch not taken
    push_step(8'h06, 0, 1, 1, 1, 8'h05, 0);  // 05 jump
    push_step(8'h05, 2, 0, 1, 0, 8'h20, 0);  // 20 branch_not taken
    push_step(8'h20, 0, 0, 1, 1, 8'h99, 0);  // 21 branch_not not taken
    push_step(8'h21, 0, 1, 1, 1, 8'h05, 0);  // 05 jump with zero=1
    push_step(8'h05, 0, 1, 1, 0, 8'h20, 0);  // 20 jump with zero=0
    push_step(8'h20, 0, 1, 1, 1, 8'hFF, 0);  // FF
    push_step(8'hFF, 0, 0, 0, 0, 8'h00, 5);  // 00 wrap, 5 hold cycles
    push_step(8'h00, 0, 1, 1, 0, 8'h40, 0);  // 40
    fq.push_back('{addr: 8'h40, dly: 0});    // halt word, no issue
    dq.push_back(0);

    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0;
    check("idle_no_req", 32'(imem_req), 32'h0);
    mon_en = 1;

    n = 0;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(halted), 32'h1);
    check("halt_instr", 32'(instr), 32'hF000);
    check("halt_opcode", 32'(opcode), 32'hF);
    check("halt_valid", 32'(instr_valid), 32'h0);
    check("halt_pc", 32'(pc), 32'h40);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_no_req", 32'(imem_req), 32'h0);
      check("halt_pc_frozen", 32'(pc), 32'h40);
    end
    check("fetch_queue_drained", 32'(fq.size()), 32'h0);
    check("issue_queue_drained", 32'(iq.size()), 32'h0);

    mon_en = 0;
    man    = 1;
    imem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("halt_rst_pc", 32'(pc), 32'h00);
    check("halt_rst_halted", 32'(halted), 32'h0);
    check("halt_rst_instr", 32'(instr), 32'h0000);
    rst = 1'b0;
    check("idle2_no_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    check("fetch2_req", 32'(imem_req), 32'h1);
    check("fetch2_addr", 32'(imem_addr), 32'h00);

    // Reset collides with an ack during fetch
    imem_ack   = 1'b1;
    imem_rdata = 16'h5678;
    rst        = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    check("abort_instr", 32'(instr), 32'h0000);
    check("abort_opcode", 32'(opcode), 32'h0);
    check("abort_valid", 32'(instr_valid), 32'h0);
    check("abort_idle", 32'(imem_req), 32'h0);
    check("abort_pc", 32'(pc), 32'h00);
    @(negedge clk);
    check("refetch_req", 32'(imem_req), 32'h1);
    check("refetch_addr", 32'(imem_addr), 32'h00);
    imem_ack   = 1'b1;
    imem_rdata = 16'h5678;
    @(negedge clk);
    imem_ack = 1'b0;
    check("refetch_valid", 32'(instr_valid), 32'h1);
    check("refetch_instr", 32'(instr), 32'h5678);
    check("refetch_opcode", 32'(opcode), 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
